// File: rtl/cnt_pkg.sv
// Shared definitions for the down-counter with prescaler (cnt_down_w_dll).
// Holds the FSM state encoding, the count width and a load-clamp helper.
package cnt_pkg;

    // Width of the count register and the preset port
    localparam int CNT_W = 7;

    // FSM states with fixed encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Limit a requested preset to the largest loadable value
    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] value,
                                                    input logic [CNT_W-1:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for cnt_down_w_dll: produces a one-cycle clock enable (tick)
// after every 2*(half+1) enabled clk cycles. The counter holds when en is
// low, and clr returns it to zero (clr wins over en).
module tick_gen #(
    parameter int half = 49
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PERIOD = 2 * (half + 1);
    localparam int W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    // The tick is a clock enable for the final enabled cycle of each period
    assign tick = en && (cnt == LAST);

    // Count enabled cycles, wrapping back to zero after the last one
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cnt_down_w_dll.sv
// Loadable down-counter with start/pause control and a built-in prescaler.
// out decrements once per prescaler tick while running; reaching zero
// enters DONE and raises expired until the next load or reset.
// Optional feature: define CNT_DOWN_AUTO_RELOAD_EN to make the counter
// reload from the last loaded value one tick after reaching zero, pulsing
// expired for one cycle instead of stopping.
module cnt_down_w_dll
    import cnt_pkg::*;
#(
    parameter int half       = 49,
    parameter int count_from = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             load,
    input  logic [CNT_W-1:0] preset,
    output logic [CNT_W-1:0] out,
    output logic             expired
);

    localparam logic [CNT_W-1:0] MAX_LOAD = CNT_W'(count_from - 1);

    state_t state;
    logic   tick;
    logic   pre_en;
    logic   pre_clr;

`ifdef CNT_DOWN_AUTO_RELOAD_EN
    logic [CNT_W-1:0] reload_reg;
`endif

    // Prescaler advances only while running; a load or a fresh start resets its phase
    assign pre_en  = (state == RUN);
    assign pre_clr = load || ((state == IDLE) && start_stop);

    tick_gen #(
        .half (half)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // Control FSM with registered count and expired flag; load beats ticks and start_stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            out     <= '0;
            expired <= 1'b0;
`ifdef CNT_DOWN_AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else if (load) begin
            state   <= IDLE;
            out     <= clamp_load(preset, MAX_LOAD);
            expired <= 1'b0;
`ifdef CNT_DOWN_AUTO_RELOAD_EN
            reload_reg <= clamp_load(preset, MAX_LOAD);
`endif
        end else begin
            // expired is held only in DONE; any other set is a one-edge event below
            expired <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        if (out == '0) begin
                            state   <= DONE;
                            expired <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef CNT_DOWN_AUTO_RELOAD_EN
                    if (tick) begin
                        if (out == '0) begin
                            out     <= reload_reg;
                            expired <= 1'b1;
                        end else begin
                            out <= out - CNT_W'(1);
                        end
                    end
                    if (!start_stop) begin
                        state <= PAUSE;
                    end
`else
                    if (tick && ((out == CNT_W'(1)) || (out == '0))) begin
                        out     <= '0;
                        state   <= DONE;
                        expired <= 1'b1;
                    end else begin
                        if (tick) begin
                            out <= out - CNT_W'(1);
                        end
                        if (!start_stop) begin
                            state <= PAUSE;
                        end
                    end
`endif
                end
                PAUSE: begin
                    if (start_stop) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_down_w_dll.sv
// Self-checking bench for cnt_down_w_dll (half=1 -> tick every 4 run cycles, count_from=60).
module tb_cnt_down_w_dll;
    import cnt_pkg::*;

    localparam int HALF       = 1;
    localparam int COUNT_FROM = 60;
    localparam int PERIOD     = 2 * (HALF + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [6:0] preset = '0;
    logic [6:0] out;
    logic       expired;

    int n_checks = 0;
    int n_fail   = 0;

    cnt_down_w_dll #(
        .half       (HALF),
        .count_from (COUNT_FROM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .load       (load),
        .preset     (preset),
        .out        (out),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;
    mmode_t m_mode;
    int     m_out;
    int     m_reload;
    int     m_runs;     // run cycles since the last start/load
    bit     m_exp;

    task automatic model_reset();
        m_mode = M_IDLE; m_out = 0; m_reload = 0; m_runs = 0; m_exp = 1'b0;
    endtask

    task automatic model_step(input bit ld, input int pre, input bit ss);
        bit tk;
        if (ld) begin
            m_out    = (pre >= COUNT_FROM) ? COUNT_FROM - 1 : pre;
            m_reload = m_out;
            m_mode   = M_IDLE;
            m_exp    = 1'b0;
            m_runs   = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (ss) begin
                if (m_out == 0) begin m_mode = M_DONE; m_exp = 1'b1; end
                else begin m_mode = M_RUN; m_runs = 0; end
            end
            M_RUN: begin
                m_runs = m_runs + 1;
                tk = (m_runs % PERIOD) == 0;
`ifdef CNT_DOWN_AUTO_RELOAD_EN
                m_exp = 1'b0;
                if (tk) begin
                    if (m_out == 0) begin m_out = m_reload; m_exp = 1'b1; end
                    else m_out = m_out - 1;
                end
                if (!ss) m_mode = M_PAUSE;
`else
                if (tk) m_out = (m_out > 0) ? m_out - 1 : 0;
                if (tk && m_out == 0) begin m_mode = M_DONE; m_exp = 1'b1; end
                else if (!ss) m_mode = M_PAUSE;
`endif
            end
            M_PAUSE: begin
                m_exp = 1'b0;
                if (ss) m_mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and compare with it
    task automatic step(input bit ld, input logic [6:0] pre, input bit ss);
        load = ld; preset = pre; start_stop = ss;
        @(posedge clk);
        #1;
        model_step(ld, int'(pre), ss);
        check("model_out", 32'(out), 32'(m_out));
        check("model_expired", 32'(expired), 32'(m_exp));
    endtask

    typedef struct {
        bit         ld;
        logic [6:0] pre;
        bit         ss;
        logic [6:0] e_out;
        bit         e_exp;
    } vec_t;

    function automatic vec_t mk(input bit ld, input logic [6:0] pre, input bit ss,
                                input logic [6:0] e_out, input bit e_exp);
        vec_t v;
        v.ld = ld; v.pre = pre; v.ss = ss; v.e_out = e_out; v.e_exp = e_exp;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        bit exp_done;

        // Directed table: clamping, zero start, DONE hold, load priority
        vecs[0]  = mk(1'b1, 7'd100, 1'b0, 7'd59, 1'b0);
        vecs[1]  = mk(1'b1, 7'd59,  1'b0, 7'd59, 1'b0);
        vecs[2]  = mk(1'b1, 7'd60,  1'b0, 7'd59, 1'b0);
        vecs[3]  = mk(1'b1, 7'd0,   1'b0, 7'd0,  1'b0);
        vecs[4]  = mk(1'b0, 7'd0,   1'b1, 7'd0,  1'b1);
        vecs[5]  = mk(1'b0, 7'd0,   1'b0, 7'd0,  1'b1);
        vecs[6]  = mk(1'b0, 7'd0,   1'b1, 7'd0,  1'b1);
        vecs[7]  = mk(1'b1, 7'd3,   1'b1, 7'd3,  1'b0);
        vecs[8]  = mk(1'b0, 7'd0,   1'b1, 7'd3,  1'b0);
        vecs[9]  = mk(1'b1, 7'd10,  1'b1, 7'd10, 1'b0);
        vecs[10] = mk(1'b0, 7'd0,   1'b0, 7'd10, 1'b0);

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_expired", 32'(expired), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        model_reset();
        #10 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].ld, vecs[i].pre, vecs[i].ss);
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].e_out));
            check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].e_exp));
        end

        // Load 3 and start: 3,2,1,0 at 4-cycle spacing
        step(1'b1, 7'd3, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            step(1'b0, 7'd0, 1'b1);
`ifdef CNT_DOWN_AUTO_RELOAD_EN
            exp_done = 1'b0;
`else
            exp_done = (k >= 12);
`endif
            check($sformatf("cnt3_k%0d_out", k), 32'(out), 32'(3 - k / 4));
            check($sformatf("cnt3_k%0d_expired", k), 32'(expired), 32'(exp_done));
        end
`ifndef CNT_DOWN_AUTO_RELOAD_EN
        // DONE ignores start_stop
        step(1'b0, 7'd0, 1'b0);
        step(1'b0, 7'd0, 1'b1);
        check("done_hold_out", 32'(out), 32'd0);
        check("done_hold_expired", 32'(expired), 32'd1);
`endif

        // Pause keeps both out and prescaler phase
        step(1'b1, 7'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 7'd0, 1'b1);
            check($sformatf("pre_pause%0d_out", i), 32'(out), 32'((i >= 4) ? 4 : 5));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 7'd0, 1'b0);
            check($sformatf("pause%0d_out", i), 32'(out), 32'd4);
        end
        step(1'b0, 7'd0, 1'b1);
        check("resume0_out", 32'(out), 32'd4);
        step(1'b0, 7'd0, 1'b1);
        check("resume1_out", 32'(out), 32'd4);
        step(1'b0, 7'd0, 1'b1);
        check("resume2_out", 32'(out), 32'd3);

        // Load in the same cycle as a tick at out=2
        step(1'b1, 7'd3, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 7'd0, 1'b1);
        check("pre_tick_out", 32'(out), 32'd2);
        step(1'b1, 7'd9, 1'b1);
        check("load_tick_out", 32'(out), 32'd9);
        check("load_tick_expired", 32'(expired), 32'd0);
        step(1'b0, 7'd0, 1'b0);
        check("load_tick_hold", 32'(out), 32'd9);

        // Reset mid-count at out=7
        step(1'b1, 7'd10, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 7'd0, 1'b1);
        check("pre_rst_out", 32'(out), 32'd7);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_expired", 32'(expired), 32'd0);
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        model_reset();
        @(posedge clk);
        #1;
        check("held_rst_out", 32'(out), 32'd0);
        #2 rst = 1'b1;
        step(1'b0, 7'd0, 1'b1);
        check("post_rst_start_expired", 32'(expired), 32'd1);
        step(1'b1, 7'd4, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 7'd0, 1'b1);
        check("post_rst_first_dec", 32'(out), 32'd3);

`ifdef CNT_DOWN_AUTO_RELOAD_EN
        // Auto reload: 2,1,0,2,1,0 with a one-cycle expired at each reload
        step(1'b1, 7'd2, 1'b0);
        for (int k = 0; k <= 26; k++) begin
            step(1'b0, 7'd0, 1'b1);
            check($sformatf("auto_k%0d_out", k), 32'(out), 32'(2 - (k / 4) % 3));
            check($sformatf("auto_k%0d_expired", k), 32'(expired), 32'((k > 0) && (k % 12 == 0)));
        end
`endif

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, 7'($urandom_range(0, 127)),
                 $urandom_range(0, 7) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
